// File: rtl/gpi_debounce_pkg.sv
// gpi_debounce_pkg: shared defaults and counter sizing for the GPI debouncer
package gpi_debounce_pkg;

    localparam int GpiDebounceCyclesDefault = 500000;
    localparam int GpiWidthDefault          = 8;

    // Counter must hold DebounceCycles-1; never narrower than one bit
    function automatic int cnt_width(input int cycles);
        return (cycles <= 1) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: one input bit's synchroniser, debounce counter, stable level and edge pulses
module debounce_bit
    import gpi_debounce_pkg::*;
#(
    parameter int   DebounceCycles = GpiDebounceCyclesDefault,
    parameter logic ResetValue     = 1'b0
) (
    input  logic clk_sys_i,
    input  logic rst_sys_ni,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int              CntW   = cnt_width(DebounceCycles);
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

    (* ASYNC_REG = "TRUE" *) logic s1;
    (* ASYNC_REG = "TRUE" *) logic s2;

    logic [CntW-1:0] cnt;
    logic [CntW-1:0] cnt_d;
    logic            differs;
    logic            accept;
    logic            stable_d;
    logic            rise_d;
    logic            fall_d;

    // Two-flop synchroniser; resets to ResetValue so reset itself never looks like an edge
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            s1 <= ResetValue;
            s2 <= ResetValue;
        end else begin
            s1 <= raw_i;
            s2 <= s1;
        end
    end

    // Count consecutive samples that disagree with the stable level; any agreement restarts the interval
    always_comb begin
        differs  = s2 != stable_o;
        accept   = differs && (cnt == CntMax);
        cnt_d    = (!differs || accept) ? '0 : cnt + 1'b1;
        stable_d = accept ? s2 : stable_o;
        rise_d   = accept && s2;
        fall_d   = accept && !s2;
    end

    // Counter, stable level and registered pulses aligned with the new stable value
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            cnt      <= '0;
            stable_o <= ResetValue;
            rise_o   <= 1'b0;
            fall_o   <= 1'b0;
        end else begin
            cnt      <= cnt_d;
            stable_o <= stable_d;
            rise_o   <= rise_d;
            fall_o   <= fall_d;
        end
    end

endmodule

// File: rtl/gpi_debounce.sv
// gpi_debounce: per-bit synchronise and debounce of board switch/button inputs
module gpi_debounce
    import gpi_debounce_pkg::*;
#(
    parameter int               Width          = GpiWidthDefault,
    parameter int               DebounceCycles = GpiDebounceCyclesDefault,
    parameter logic [Width-1:0] ResetValue     = '0
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_ni,
    input  logic [Width-1:0] raw_i,
    output logic [Width-1:0] stable_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o
);

    for (genvar i = 0; i < Width; i++) begin : g_bit
        debounce_bit #(
            .DebounceCycles(DebounceCycles),
            .ResetValue    (ResetValue[i])
        ) u_bit (
            .clk_sys_i (clk_sys_i),
            .rst_sys_ni(rst_sys_ni),
            .raw_i     (raw_i[i]),
            .stable_o  (stable_o[i]),
            .rise_o    (rise_o[i]),
            .fall_o    (fall_o[i])
        );
    end

endmodule

// File: tb/tb_gpi_debounce.sv
// tb_gpi_debounce: directed and randomized checks of gpi_debounce against a window-based model
module tb_gpi_debounce;

    localparam int W  = 8;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] raw = '0;
    logic [W-1:0] stable;
    logic [W-1:0] rise;
    logic [W-1:0] fall;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gpi_debounce #(
        .Width         (W),
        .DebounceCycles(DC),
        .ResetValue    ('0)
    ) dut (
        .clk_sys_i (clk),
        .rst_sys_ni(rst_n),
        .raw_i     (raw),
        .stable_o  (stable),
        .rise_o    (rise),
        .fall_o    (fall)
    );

    // Reference: a bit flips when the last DC synchronised samples all disagree with it
    logic [W-1:0] hist[$];
    logic [W-1:0] m_stable;
    logic [W-1:0] m_rise;
    logic [W-1:0] m_fall;
    logic         all_diff;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist = {};
            repeat (DC + 2) hist.push_back('0);
            m_stable = '0;
            m_rise   = '0;
            m_fall   = '0;
        end else begin
            hist.push_back(raw);
            void'(hist.pop_front());
            m_rise = '0;
            m_fall = '0;
            for (int b = 0; b < W; b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < DC; j++)
                    if (hist[j][b] == m_stable[b]) all_diff = 1'b0;
                if (all_diff) begin
                    m_stable[b] = ~m_stable[b];
                    m_rise[b]   = m_stable[b];
                    m_fall[b]   = ~m_stable[b];
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        raw   = '1;
        repeat (3) cyc();
        tests++; if (stable !== 8'h00) begin fails++; $display("FAIL reset_stable got %h want 00", stable); end
        tests++; if (rise !== 8'h00) begin fails++; $display("FAIL reset_rise got %h want 00", rise); end
        tests++; if (fall !== 8'h00) begin fails++; $display("FAIL reset_fall got %h want 00", fall); end
        raw   = '0;
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            cyc();
            tests++; if ((rise | fall) !== 8'h00) begin fails++; $display("FAIL post_reset_pulse cyc %0d got %h want 00", c, rise | fall); end
            tests++; if (stable !== 8'h00) begin fails++; $display("FAIL post_reset_stable cyc %0d got %h want 00", c, stable); end
        end
    endtask

    task automatic test_clean_rise();
        raw = 8'h01;
        for (int e = 1; e <= 8; e++) begin
            cyc();
            tests++; if (stable !== (e >= 6 ? 8'h01 : 8'h00)) begin fails++; $display("FAIL rise_stable edge %0d got %h want %h", e, stable, (e >= 6 ? 8'h01 : 8'h00)); end
            tests++; if (rise !== (e == 6 ? 8'h01 : 8'h00)) begin fails++; $display("FAIL rise_pulse edge %0d got %h want %h", e, rise, (e == 6 ? 8'h01 : 8'h00)); end
            tests++; if (fall !== 8'h00) begin fails++; $display("FAIL rise_fall edge %0d got %h want 00", e, fall); end
        end
    endtask

    task automatic test_glitch();
        int pulses;
        raw[1] = 1'b1;
        repeat (3) cyc();
        raw[1] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            tests++; if (rise[1] !== 1'b0 || stable[1] !== 1'b0) begin fails++; $display("FAIL glitch3 cyc %0d got rise=%b stable=%b want 0 0", c, rise[1], stable[1]); end
        end
        pulses = 0;
        raw[1] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            pulses += int'(rise[1]);
        end
        raw[1] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            cyc();
            pulses += int'(rise[1]);
        end
        tests++; if (pulses !== 1) begin fails++; $display("FAIL glitch4_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_bounce();
        int pulses;
        int first;
        repeat (10) cyc();
        pulses = 0;
        first  = -1;
        for (int c = 0; c < 20; c++) begin
            if (c % 2 == 0) raw[2] = ~raw[2];
            cyc();
            pulses += int'(rise[2]);
        end
        raw[2] = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            cyc();
            if (rise[2] && first < 0) first = e;
            pulses += int'(rise[2]);
        end
        tests++; if (pulses !== 1) begin fails++; $display("FAIL bounce_pulses got %0d want 1", pulses); end
        tests++; if (first !== 6) begin fails++; $display("FAIL bounce_edge got %0d want 6", first); end
    endtask

    task automatic test_fall();
        raw = 8'hF8;
        repeat (12) cyc();
        tests++; if (stable !== 8'hF8) begin fails++; $display("FAIL fall_setup got %h want f8", stable); end
        raw = 8'h08;
        for (int e = 1; e <= 8; e++) begin
            cyc();
            tests++; if (fall !== (e == 6 ? 8'hF0 : 8'h00)) begin fails++; $display("FAIL fall_pulse edge %0d got %h want %h", e, fall, (e == 6 ? 8'hF0 : 8'h00)); end
            tests++; if (rise !== 8'h00) begin fails++; $display("FAIL fall_rise edge %0d got %h want 00", e, rise); end
            tests++; if (stable !== (e >= 6 ? 8'h08 : 8'hF8)) begin fails++; $display("FAIL fall_stable edge %0d got %h want %h", e, stable, (e >= 6 ? 8'h08 : 8'hF8)); end
        end
    endtask

    task automatic test_reset_mid();
        raw = 8'h00;
        repeat (12) cyc();
        raw[4] = 1'b1;
        repeat (3) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (stable !== 8'h00 || rise !== 8'h00 || fall !== 8'h00) begin fails++; $display("FAIL midreset_async got %h/%h/%h want 00/00/00", stable, rise, fall); end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            cyc();
            tests++; if (rise !== (e == 6 ? 8'h10 : 8'h00)) begin fails++; $display("FAIL midreset_rise edge %0d got %h want %h", e, rise, (e == 6 ? 8'h10 : 8'h00)); end
            tests++; if (stable !== (e >= 6 ? 8'h10 : 8'h00)) begin fails++; $display("FAIL midreset_stable edge %0d got %h want %h", e, stable, (e >= 6 ? 8'h10 : 8'h00)); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            cyc();
            tests++; if (stable !== m_stable) begin fails++; $display("FAIL rnd_stable cyc %0d got %h want %h", c, stable, m_stable); end
            tests++; if (rise !== m_rise) begin fails++; $display("FAIL rnd_rise cyc %0d got %h want %h", c, rise, m_rise); end
            tests++; if (fall !== m_fall) begin fails++; $display("FAIL rnd_fall cyc %0d got %h want %h", c, fall, m_fall); end
            tests++; if ((rise & fall) !== 8'h00) begin fails++; $display("FAIL rnd_both cyc %0d got %h want 00", c, rise & fall); end
            raw = raw ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_glitch();
        test_bounce();
        test_fall();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
